fifo_receptor: RTL

FIFO_RECEPTOR -- requirements
Module: fifo_receptor

---
 rtl/fifo_receptor_pkg.sv | 22 ++
 rtl/fifo_receptor_memoria_fifo.sv | 41 ++++
 rtl/fifo_receptor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fifo_receptor_pkg.sv
// Shared bus geometry for the receptor FIFO and the upstream state machine,
// plus the per-cycle FIFO operation encoding.
package fifo_receptor_pkg;

  localparam int BUS_SIZE    = 16;
  localparam int WORD_SIZE   = 4;
  localparam int WORD_NUM    = BUS_SIZE / WORD_SIZE;
  localparam int DEPTH       = 8;
  localparam int ALMOST_FULL = 6;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e encode_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_receptor_memoria_fifo.sv
// Storage array for the receptor FIFO: one write port, one registered read port.
// Only the read register is reset so data_out starts at zero; the array is not.
module memoria_fifo
  import fifo_receptor_pkg::*;
#(
  parameter int Width  = WORD_NUM + BUS_SIZE,
  parameter int Depth  = DEPTH,
  parameter int Addr_W = $clog2(Depth)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [Addr_W-1:0] wr_addr,
  input  logic [Width-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [Addr_W-1:0] rd_addr,
  output logic [Width-1:0]  rd_data
);

  logic [Width-1:0] mem_r [Depth];
  logic [Width-1:0] rd_data_r;

  // Array write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read port; reads the pre-write value when addresses collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_r <= {Width{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_receptor.sv
// Receptor FIFO: buffers masked words from the upstream state machine, drops
// words flagged in error (counting them), and hands them to a consumer on rd_en.
module fifo_receptor
  import fifo_receptor_pkg::*;
#(
  parameter int Bus_Size    = BUS_SIZE,
  parameter int Word_Size   = WORD_SIZE,
  parameter int Depth       = DEPTH,
  parameter int Almost_Full = ALMOST_FULL,
  localparam int Word_Num   = Bus_Size / Word_Size
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [Bus_Size-1:0] bus_in,
  input  logic [Word_Num-1:0] control_in,
  input  logic                error_in,
  input  logic                rd_en,
  output logic [Bus_Size-1:0] data_out,
  output logic [Word_Num-1:0] mask_out,
  output logic                valid_out,
  output logic                empty,
  output logic                full,
  output logic                almost_full,
  output logic                overflow,
  output logic                underflow,
  output logic [7:0]          err_count
);

  localparam int Ptr_W   = $clog2(Depth);
  localparam int Entry_W = Word_Num + Bus_Size;

  logic [Ptr_W-1:0]   wr_ptr_r;
  logic [Ptr_W-1:0]   rd_ptr_r;
  logic [Ptr_W:0]     count_r;
  logic               valid_r;
  logic               overflow_r;
  logic               underflow_r;
  logic [7:0]         err_count_r;

  logic               present_s;
  logic               push_req_s;
  logic               reject_s;
  logic               empty_s;
  logic               full_s;
  logic               pop_s;
  logic               push_s;
  fifo_op_e           op_s;
  logic [Entry_W-1:0] rd_entry_s;

  assign empty_s    = (count_r == (Ptr_W+1)'(0));
  assign full_s     = (count_r == (Ptr_W+1)'(Depth));
  assign present_s  = |control_in;
  assign push_req_s = present_s & ~error_in;
  assign reject_s   = present_s & error_in;
  assign pop_s      = rd_en & ~empty_s;
  // A full FIFO still accepts a word when a pop frees its slot this cycle.
  assign push_s     = push_req_s & (~full_s | pop_s);
  assign op_s       = encode_op(push_s, pop_s);

  // Pointer, occupancy, sticky flag, error counter and valid pulse state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r    <= {Ptr_W{1'b0}};
      rd_ptr_r    <= {Ptr_W{1'b0}};
      count_r     <= {(Ptr_W+1){1'b0}};
      valid_r     <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      err_count_r <= 8'h00;
    end else begin
      case (op_s)
        OP_PUSH: begin
          wr_ptr_r <= wr_ptr_r + Ptr_W'(1);
          count_r  <= count_r + (Ptr_W+1)'(1);
        end
        OP_POP: begin
          rd_ptr_r <= rd_ptr_r + Ptr_W'(1);
          count_r  <= count_r - (Ptr_W+1)'(1);
        end
        OP_BOTH: begin
          wr_ptr_r <= wr_ptr_r + Ptr_W'(1);
          rd_ptr_r <= rd_ptr_r + Ptr_W'(1);
        end
        default: begin
          count_r <= count_r;
        end
      endcase
      valid_r <= pop_s;
      if (push_req_s && full_s && !rd_en) begin
        overflow_r <= 1'b1;
      end
      if (rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end
      if (reject_s && (err_count_r != 8'hFF)) begin
        err_count_r <= err_count_r + 8'h01;
      end
    end
  end

  memoria_fifo #(
    .Width (Entry_W),
    .Depth (Depth),
    .Addr_W(Ptr_W)
  ) u_memoria_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push_s),
    .wr_addr(wr_ptr_r),
    .wr_data({control_in, bus_in}),
    .rd_en  (pop_s),
    .rd_addr(rd_ptr_r),
    .rd_data(rd_entry_s)
  );

  assign data_out    = rd_entry_s[Bus_Size-1:0];
  assign mask_out    = rd_entry_s[Entry_W-1:Bus_Size];
  assign valid_out   = valid_r;
  assign empty       = empty_s;
  assign full        = full_s;
  assign almost_full = (count_r >= (Ptr_W+1)'(Almost_Full));
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;
  assign err_count   = err_count_r;

endmodule
